uart_word_link: RTL and testbench
=================================

UART_WORD_LINK -- requirements
Module: uart_word_link

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter CLKS_PER_BIT, default 434: CLK cycles per serial bit (50 MHz / 115200); SHALL be >= 4.
REQ-003 Parameter PARITY_EN, default 0: 1 = even parity bit after the 8 data bits of every byte.
REQ-004 Parameter TIMEOUT_BITS, default 16: maximum idle bit-times between bytes of one RX word.
REQ-005 CLK  input  1  single clock; all logic on its rising edge.
REQ-006 RST_N  input  1  synchronous, active-low reset.
REQ-007 tx_data  input  DATA_W  word to send.
REQ-008 tx_valid  input  1  tx_data valid.
REQ-009 tx_ready  output  1  transmitter accepts a word.
REQ-010 tx_done  output  1  one-cycle pulse: final stop bit of the word finished.
REQ-011 TX  output  1  serial out, idle high.
REQ-012 RX  input  1  serial in, asynchronous.
REQ-013 rx_data  output  DATA_W  last received word; held until the next word completes.
REQ-014 rx_valid  output  1  one-cycle pulse: rx_data and rx_err updated.
REQ-015 rx_err  output  2  [0] framing error, [1] parity error; sticky across the bytes of one word.
REQ-016 rx_timeout  output  1  one-cycle pulse: partial word discarded.

Function
REQ-017 Frame per byte SHALL be: start (0), 8 data bits LSB first, parity if PARITY_EN, stop (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-018 Words SHALL be sent and received as DATA_W/8 bytes, least-significant byte first.
REQ-019 TX states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-020 tx_ready SHALL be high only in IDLE; a handshake (tx_valid && tx_ready) latches tx_data, drops tx_ready the next cycle, and drives TX low from the next cycle.
REQ-021 Bytes of one word SHALL be sent back-to-back: STOP of byte n is followed directly by START of byte n+1.
REQ-022 On the final cycle of the last STOP, tx_done SHALL pulse; tx_ready SHALL be high on the following cycle.
REQ-023 tx_data and tx_valid changes during a transmission SHALL be ignored.
REQ-024 RX SHALL pass through a 2-flop synchroniser; a high-to-low transition on the synchronised signal in RX IDLE starts a frame.
REQ-025 The start bit SHALL be re-sampled at CLKS_PER_BIT/2 cycles; if high, the frame is aborted and RX returns to IDLE with no flags set.
REQ-026 Data, parity, and stop bits SHALL be sampled at bit centres, at CLKS_PER_BIT-cycle intervals from the start-bit centre.
REQ-027 A stop sample of 0 SHALL set rx_err[0]; an odd-parity byte (PARITY_EN=1) SHALL set rx_err[1].
REQ-028 After the stop sample of the last byte, rx_data, rx_err, and the rx_valid pulse SHALL appear together on the next cycle; error accumulators then clear.
REQ-029 After a non-final byte, if no start edge arrives within TIMEOUT_BITS*CLKS_PER_BIT cycles, the partial word and error accumulators SHALL be discarded, rx_timeout pulses, and rx_data is left unchanged.
REQ-030 With DATA_W=8, no timeout SHALL ever occur.
REQ-031 TX and RX SHALL be fully independent; simultaneous operation is legal.

Reset
REQ-032 While RST_N=0 at a clock edge: TX=1, tx_ready=0, tx_done=0, rx_valid=0, rx_timeout=0, rx_data=0, rx_err=0, both FSMs in IDLE, synchroniser flops = 1, and all counters = 0.
REQ-033 tx_ready SHALL go high on the first edge after RST_N returns high.
REQ-034 Reset mid-frame SHALL abort the frame immediately: TX is high on the next cycle, and no done or valid pulse is produced.

Structure
REQ-035 Package uart_word_pkg SHALL hold the TX and RX state enums, the rx_err bit index constants, and the default CLKS_PER_BIT.
REQ-036 A sub-module uart_bit_timer (cycle counter with a reload input, bit-end pulse, and mid-bit pulse) SHALL be instantiated once each by the TX path and the RX path.

Verification
REQ-037 Use CLKS_PER_BIT=4 and DATA_W=32 unless stated; the bench provides a serial model on TX/RX.
REQ-038 Send tx_data=0xA5C3_0F81 with PARITY_EN=0 -> TX shows bytes 0x81, 0x0F, 0xC3, 0xA5 LSB first; tx_done pulses exactly 160 cycles after the handshake; tx_ready is high the next cycle.
REQ-039 Loop TX to RX and send 0xDEADBEEF -> rx_valid pulses once, rx_data=0xDEADBEEF, rx_err=00.
REQ-040 With PARITY_EN=1, inject byte 0x03 with parity bit 1 as byte 2 -> rx_valid pulses with rx_err=10; the next clean word gives rx_err=00.
REQ-041 Inject 2 bytes, then idle 64 cycles -> rx_timeout pulses at cycle 64, no rx_valid, and rx_data is unchanged; a following full word is received correctly.
REQ-042 Drive RX low for a 1-cycle glitch -> no rx_valid, no error flags; in a separate run, inject a stop bit of 0 on byte 0 -> rx_err=01 at word end.
REQ-043 Assert RST_N=0 during byte 1 of TX -> TX=1 next cycle, no tx_done; after release, tx_ready=1 and a fresh word transmits correctly.

Source files
------------

// File: rtl/uart_word_pkg.sv
// Shared types and constants for the word-oriented UART link:
// FSM state encodings, rx_err bit positions and the default bit period.
package uart_word_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam int RX_ERR_FRAME  = 0;
  localparam int RX_ERR_PARITY = 1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps every CLKS_PER_BIT enabled cycles, pulsing at
// the last cycle of a bit and at the bit centre; reload restarts at zero.
module uart_bit_timer
  import uart_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic reload_i,
  input  logic en_i,
  output logic bit_end_o,
  output logic mid_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && !reload_i && (cnt_q == LAST);
  assign mid_o     = en_i && !reload_i && (cnt_q == MID);

endmodule

// File: rtl/uart_word_link.sv
// Word-wide UART: sends and receives DATA_W-bit words as LSB-first byte
// frames with optional even parity, plus an inter-byte receive timeout.
module uart_word_link
  import uart_word_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              TX,
  input  logic              RX,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [1:0]        rx_err,
  output logic              rx_timeout,
  output logic [2:0]        tx_state_o,
  output logic [2:0]        rx_state_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [3:0]  LAST_BYTE = 4'(NBYTES - 1);
  // The pulse is registered, so fire one count early to land exactly
  // TIMEOUT_BITS*CLKS_PER_BIT cycles after the stop sample.
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 2);

  // ---------------- transmitter ----------------
  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [3:0]        tx_byte_q, tx_byte_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_q, tx_d;
  logic              tx_rdy_q;
  logic              tx_hs, tx_bit_end, tx_mid_unused;

  // Handshake: a word transfers on any edge where tx_valid && tx_ready;
  // tx_ready is registered and only high while idle, so valid may drop freely.
  assign tx_hs = tx_valid && tx_rdy_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .reload_i (tx_hs),
    .en_i     (tx_state_q != TX_IDLE),
    .bit_end_o(tx_bit_end),
    .mid_o    (tx_mid_unused)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_word_d  = tx_word_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: if (tx_hs) begin
        tx_word_d  = tx_data;
        tx_byte_d  = 4'd0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_bit_end) begin
        tx_bit_d   = 3'd0;
        tx_par_d   = 1'b0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_par_d  = tx_par_q ^ tx_word_q[0];
        tx_word_d = tx_word_q >> 1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (tx_byte_q == LAST_BYTE) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_byte_d  = tx_byte_q + 4'd1;
          tx_state_d = TX_START;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the next state so TX changes on the same edge.
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_word_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_state_q <= TX_IDLE;
      tx_word_q  <= '0;
      tx_bit_q   <= 3'd0;
      tx_byte_q  <= 4'd0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_word_q  <= tx_word_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_rdy_q   <= (tx_state_d == TX_IDLE);
    end
  end

  assign TX         = tx_q;
  assign tx_ready   = tx_rdy_q;
  assign tx_done    = RST_N && (tx_state_q == TX_STOP) && tx_bit_end && (tx_byte_q == LAST_BYTE);
  assign tx_state_o = tx_state_q;

  // ---------------- receiver ----------------
  rx_state_e         rx_state_q, rx_state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [3:0]        rx_byte_q, rx_byte_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;
  logic              rx_par_q, rx_par_d;
  logic [1:0]        rx_eacc_q, rx_eacc_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [1:0]        rx_err_q, rx_err_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_to_q, rx_to_d;
  logic [31:0]       to_cnt_q, to_cnt_d;
  logic              rx_s, start_edge, rx_go, rx_mid, rx_bit_end_unused;

  assign rx_s       = sync2_q;
  assign start_edge = prev_q && !sync2_q;
  assign rx_go      = (rx_state_q == RX_IDLE) && start_edge;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .reload_i (rx_go),
    .en_i     (rx_state_q != RX_IDLE),
    .bit_end_o(rx_bit_end_unused),
    .mid_o    (rx_mid)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_byte_d  = rx_byte_q;
    rx_shift_d = rx_shift_q;
    rx_word_d  = rx_word_q;
    rx_par_d   = rx_par_q;
    rx_eacc_d  = rx_eacc_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    rx_valid_d = 1'b0;
    rx_to_d    = 1'b0;
    to_cnt_d   = to_cnt_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (start_edge) begin
          to_cnt_d   = 32'd0;
          rx_state_d = RX_START;
        end else if (rx_byte_q != 4'd0) begin
          if (to_cnt_q == TO_LAST) begin
            rx_byte_d = 4'd0;
            rx_eacc_d = 2'b00;
            to_cnt_d  = 32'd0;
            rx_to_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
        end
      end
      RX_START: if (rx_mid) begin
        // A start bit that is high again at its centre was only a glitch.
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_bit_d   = 3'd0;
          rx_par_d   = 1'b0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: if (rx_mid) begin
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_par_d   = rx_par_q ^ rx_s;
        if (rx_bit_q == 3'd7) begin
          rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: if (rx_mid) begin
        rx_par_d   = rx_par_q ^ rx_s;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_mid) begin
        if (!rx_s) rx_eacc_d[RX_ERR_FRAME] = 1'b1;
        if ((PARITY_EN != 0) && rx_par_q) rx_eacc_d[RX_ERR_PARITY] = 1'b1;
        for (int b = 0; b < NBYTES; b++) begin
          if (rx_byte_q == 4'(b)) rx_word_d[b*8 +: 8] = rx_shift_q;
        end
        to_cnt_d   = 32'd0;
        rx_state_d = RX_IDLE;
        if (rx_byte_q == LAST_BYTE) begin
          rx_data_d  = rx_word_d;
          rx_err_d   = rx_eacc_d;
          rx_valid_d = 1'b1;
          rx_eacc_d  = 2'b00;
          rx_byte_d  = 4'd0;
        end else begin
          rx_byte_d = rx_byte_q + 4'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= 3'd0;
      rx_byte_q  <= 4'd0;
      rx_shift_q <= 8'd0;
      rx_word_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_eacc_q  <= 2'b00;
      rx_data_q  <= '0;
      rx_err_q   <= 2'b00;
      rx_valid_q <= 1'b0;
      rx_to_q    <= 1'b0;
      to_cnt_q   <= 32'd0;
    end else begin
      sync1_q    <= RX;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_shift_q <= rx_shift_d;
      rx_word_q  <= rx_word_d;
      rx_par_q   <= rx_par_d;
      rx_eacc_q  <= rx_eacc_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
      rx_valid_q <= rx_valid_d;
      rx_to_q    <= rx_to_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_err     = rx_err_q;
  assign rx_valid   = rx_valid_q;
  assign rx_timeout = rx_to_q;
  assign rx_state_o = rx_state_q;

endmodule

// File: tb/tb_uart_word_link.sv
// Directed bench for uart_word_link: TX waveform and timing, loopback,
// parity/framing errors, inter-byte timeout, start glitch and mid-frame reset.
module tb_uart_word_link;

  localparam int CPB = 4;
  localparam int DW  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (no parity) ----------------
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, tx_done, tx_line, rx_line, rx_drv, loop_en;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_timeout;
  logic [1:0]    rx_err;
  logic [2:0]    tx_state, rx_state;

  assign rx_line = loop_en ? tx_line : rx_drv;

  uart_word_link #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .TIMEOUT_BITS(16)) u_dut (
    .CLK(clk), .RST_N(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .TX(tx_line), .RX(rx_line), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .rx_timeout(rx_timeout), .tx_state_o(tx_state), .rx_state_o(rx_state)
  );

  // ---------------- DUT (even parity) ----------------
  logic [DW-1:0] p_tx_data;
  logic          p_tx_valid, p_tx_ready, p_tx_done, p_tx_line, p_rx_drv;
  logic [DW-1:0] p_rx_data;
  logic          p_rx_valid, p_rx_timeout;
  logic [1:0]    p_rx_err;
  logic [2:0]    p_tx_state, p_rx_state;

  uart_word_link #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .TIMEOUT_BITS(16)) u_dut_p (
    .CLK(clk), .RST_N(rst_n), .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
    .tx_done(p_tx_done), .TX(p_tx_line), .RX(p_rx_drv), .rx_data(p_rx_data), .rx_valid(p_rx_valid),
    .rx_err(p_rx_err), .rx_timeout(p_rx_timeout), .tx_state_o(p_tx_state), .rx_state_o(p_rx_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [1:0]    exp_err_q[$];
  logic [DW-1:0] exp_p_q[$];
  logic [1:0]    exp_p_err_q[$];
  int done_cnt = 0;
  int to_cnt = 0;
  int p_to_cnt = 0;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (rx_timeout === 1'b1) to_cnt++;
    if (p_rx_timeout === 1'b1) p_to_cnt++;
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rx_valid_unexpected", 64'(rx_valid), 64'd0);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
        check("rx_err", rx_err, exp_err_q.pop_front());
      end
    end
    if (p_rx_valid === 1'b1) begin
      if (exp_p_q.size() == 0) begin
        check("p_rx_valid_unexpected", 64'(p_rx_valid), 64'd0);
      end else begin
        check("p_rx_data", p_rx_data, exp_p_q.pop_front());
        check("p_rx_err", p_rx_err, exp_p_err_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit sel_p, input logic v);
    if (sel_p) p_rx_drv = v;
    else rx_drv = v;
    cycles(CPB);
  endtask

  task automatic inject_byte(input bit sel_p, input logic [7:0] b, input bit with_par,
                             input logic par_bit, input logic stop_bit);
    drive_bit(sel_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel_p, b[i]);
    if (with_par) drive_bit(sel_p, par_bit);
    drive_bit(sel_p, stop_bit);
  endtask

  // Bytes LSB first, each followed by one idle bit time.
  task automatic inject_word(input bit sel_p, input logic [31:0] w, input bit with_par,
                             input int bad_par_idx, input int bad_stop_idx);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[i*8 +: 8];
      inject_byte(sel_p, b, with_par, (^b) ^ (i == bad_par_idx), (i != bad_stop_idx));
      drive_bit(sel_p, 1'b1);
    end
  endtask

  // Full transmit with waveform, tx_done timing and tx_ready checks.
  task automatic send_word(input logic [31:0] w);
    logic [9:0] exp_frame [4];
    logic [9:0] obs_frame [4];
    int bad = 0;
    int wait_c = 0;
    int done_at = -1;
    int done_n = 0;
    int bi, pos;
    for (int b = 0; b < 4; b++) begin
      exp_frame[b] = {1'b1, w[b*8 +: 8], 1'b0};
      obs_frame[b] = 10'd0;
    end
    tx_data  = w;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && wait_c < 50) begin
      cycles(1);
      wait_c++;
    end
    check("tx_ready_before_hs", 64'(tx_ready), 64'd1);
    cycles(1);
    tx_valid = 1'b0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      bi  = (k - 1) / 40;
      pos = ((k - 1) % 40) / 4;
      if (tx_line !== exp_frame[bi][pos]) bad++;
      if ((k - 1) % 4 == 1) obs_frame[bi][pos] = tx_line;
      if (tx_done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) check("tx_ready_after_hs", 64'(tx_ready), 64'd0);
      if (k == 20) begin
        tx_data  = ~w;
        tx_valid = 1'b1;
      end
      if (k == 24) tx_valid = 1'b0;
    end
    @(negedge clk);
    check("tx_ready_after_done", 64'(tx_ready), 64'd1);
    check("tx_idle_after_done", 64'(tx_line), 64'd1);
    for (int b = 0; b < 4; b++) check($sformatf("tx_frame_byte%0d", b), obs_frame[b], exp_frame[b]);
    check("tx_wave_bad_cycles", bad, 0);
    check("tx_done_cycle", done_at, 160);
    check("tx_done_pulses", done_n, 1);
    cycles(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int first_to, n_to, to_before, done_before;
    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    p_tx_data = '0; p_tx_valid = 1'b0; p_rx_drv = 1'b1;

    // Reset state
    cycles(3);
    @(negedge clk);
    check("rst_tx", 64'(tx_line), 64'd1);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_tx_done", 64'(tx_done), 64'd0);
    check("rst_rx_out", {rx_valid, rx_timeout, rx_err, rx_data}, 64'd0);
    check("rst_states", {tx_state, rx_state}, 64'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(1);
    check("tx_ready_after_rst", 64'(tx_ready), 64'd1);

    // TX waveform of 0xA5C30F81, looped back into RX
    loop_en = 1'b1;
    exp_q.push_back(32'hA5C3_0F81); exp_err_q.push_back(2'b00);
    send_word(32'hA5C3_0F81);
    cycles(10);
    check("rx_pending_a5", exp_q.size(), 0);

    // Loopback 0xDEADBEEF
    exp_q.push_back(32'hDEAD_BEEF); exp_err_q.push_back(2'b00);
    send_word(32'hDEAD_BEEF);
    cycles(10);
    check("rx_pending_dead", exp_q.size(), 0);
    loop_en = 1'b0;
    cycles(4);

    // Two bytes then idle: timeout 64 cycles after the last stop bit
    to_before = to_cnt;
    inject_byte(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    inject_byte(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    first_to = -1; n_to = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_timeout === 1'b1) begin
        n_to++;
        if (first_to < 0) first_to = k;
      end
    end
    cycles(1);
    check("timeout_cycle", first_to, 64);
    check("timeout_pulses", n_to, 1);
    check("timeout_rx_data_kept", rx_data, 32'hDEAD_BEEF);
    exp_q.push_back(32'hCAFE_F00D); exp_err_q.push_back(2'b00);
    inject_word(1'b0, 32'hCAFE_F00D, 1'b0, -1, -1);
    cycles(8);
    check("rx_pending_cafe", exp_q.size(), 0);

    // One-cycle start glitch
    rx_drv = 1'b0;
    cycles(1);
    rx_drv = 1'b1;
    cycles(40);
    check("glitch_rx_err", rx_err, 2'b00);
    check("glitch_rx_data", rx_data, 32'hCAFE_F00D);
    check("glitch_rx_state", rx_state, 3'd0);
    check("glitch_no_timeout", to_cnt - to_before, 1);
    exp_q.push_back(32'h0BAD_C0DE); exp_err_q.push_back(2'b00);
    inject_word(1'b0, 32'h0BAD_C0DE, 1'b0, -1, -1);
    cycles(8);
    check("rx_pending_0bad", exp_q.size(), 0);

    // Stop bit 0 on byte 0
    exp_q.push_back(32'h5A5A_1234); exp_err_q.push_back(2'b01);
    inject_word(1'b0, 32'h5A5A_1234, 1'b0, -1, 0);
    cycles(8);
    check("rx_pending_frame", exp_q.size(), 0);

    // Parity: byte 2 = 0x03 sent with parity bit 1, then a clean word
    exp_p_q.push_back(32'h4403_2211); exp_p_err_q.push_back(2'b10);
    inject_word(1'b1, 32'h4403_2211, 1'b1, 2, -1);
    exp_p_q.push_back(32'h1234_5678); exp_p_err_q.push_back(2'b00);
    inject_word(1'b1, 32'h1234_5678, 1'b1, -1, -1);
    cycles(8);
    check("p_rx_pending", exp_p_q.size(), 0);

    // Reset during byte 1 of a transmission
    done_before = done_cnt;
    tx_data = 32'h2468_ACE0;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    cycles(50);
    rst_n = 1'b0;
    cycles(1);
    @(negedge clk);
    check("midrst_tx", 64'(tx_line), 64'd1);
    check("midrst_tx_ready", 64'(tx_ready), 64'd0);
    check("midrst_tx_done", 64'(tx_done), 64'd0);
    check("midrst_rx_data", rx_data, 32'd0);
    check("midrst_rx_err", rx_err, 2'b00);
    check("midrst_tx_state", tx_state, 3'd0);
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tx_ready_before_edge", 64'(tx_ready), 64'd0);
    @(negedge clk);
    check("rel_tx_ready", 64'(tx_ready), 64'd1);
    check("midrst_no_done", done_cnt - done_before, 0);
    cycles(1);
    loop_en = 1'b1;
    exp_q.push_back(32'h1357_9BDF); exp_err_q.push_back(2'b00);
    send_word(32'h1357_9BDF);
    cycles(10);
    check("rx_pending_after_rst", exp_q.size(), 0);

    check("p_tx_side_idle", {p_tx_ready, p_tx_done, p_tx_line}, 3'b101);
    check("p_states_idle", {p_tx_state, p_rx_state}, 6'd0);
    check("p_no_timeout", p_to_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
